// File: rtl/decode_queue_if.sv
// Fetch/execute handshake bundle for decode_queue: enqueue side, dequeue side and
// the decoded control fields of the head entry.
interface decode_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Valid/ready: a transfer happens on a rising edge where valid && ready are both 1.
    // in_ready depends only on queue state, never on out_ready.
    logic              flush;
    logic              in_valid;
    logic [31:0]       instr_in;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [3:0]        aluop;
    logic [4:0]        shamt;
    logic              regdst;
    logic              alusrc;
    logic              extop;
    logic              memtoreg;
    logic              regwrite;
    logic              dren;
    logic              dwen;
    logic              back_pad;
    logic              datomic;
    logic [1:0]        branch;
    logic [1:0]        jump;
    logic [CNT_W-1:0]  count;
    logic              halted;
    logic              illegal;

    modport master (
        output flush, in_valid, instr_in, out_ready,
        input  in_ready, out_valid, out_instr, aluop, shamt, regdst, alusrc, extop,
               memtoreg, regwrite, dren, dwen, back_pad, datomic, branch, jump,
               count, halted, illegal
    );

    modport slave (
        input  flush, in_valid, instr_in, out_ready,
        output in_ready, out_valid, out_instr, aluop, shamt, regdst, alusrc, extop,
               memtoreg, regwrite, dren, dwen, back_pad, datomic, branch, jump,
               count, halted, illegal
    );
endinterface

// File: rtl/decode_queue.sv
// DEPTH-entry instruction queue that decodes each MIPS word on entry and presents the head.
// Optional macro DECODE_ILLEGAL_TRAP_EN: unknown words flag illegal and stop the queue like HALT.
package cpu_types_pkg;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3, ALU_XOR = 4'd4,
        ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7, ALU_SLL = 4'd8, ALU_SRL = 4'd9
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b, OP_ANDI = 6'h0c, OP_ORI  = 6'h0d, OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f, OP_LW   = 6'h23, OP_SW   = 6'h2b, OP_LL    = 6'h30;
    localparam logic [5:0] OP_SC    = 6'h38, OP_HALT = 6'h3f;

    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL  = 6'h02, FN_JR  = 6'h08, FN_ADD = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25, FN_XOR  = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    typedef struct packed {
        aluop_t      aluop;
        logic [4:0]  shamt;
        logic        regdst, alusrc, extop, memtoreg, regwrite, dren, dwen, back_pad, datomic;
        logic [1:0]  branch;
        logic [1:0]  jump;
        logic        illegal;
        logic        halt;
    } ctrl_t;
endpackage

module decode_queue #(
    parameter int DEPTH = 4
) (
    input logic          CLK,
    input logic          nRST,
    decode_queue_if.slave q
);
    import cpu_types_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [31:0]      instr_mem_q [DEPTH];
    ctrl_t            ctrl_mem_q  [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             halt_seen_q, halt_seen_d, halted_q, halted_d;
    logic             enq, deq, wr_en;
    ctrl_t            in_ctrl, head_raw, head_ctrl;

    function automatic ctrl_t decode(input logic [31:0] w);
        ctrl_t c;
        c = '0;
        case (w[31:26])
            OP_RTYPE: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
                case (w[5:0])
                    FN_SLL:          begin c.aluop = ALU_SLL; c.shamt = w[10:6]; end
                    FN_SRL:          begin c.aluop = ALU_SRL; c.shamt = w[10:6]; end
                    FN_ADD, FN_ADDU: c.aluop = ALU_ADD;
                    FN_SUB, FN_SUBU: c.aluop = ALU_SUB;
                    FN_AND:          c.aluop = ALU_AND;
                    FN_OR:           c.aluop = ALU_OR;
                    FN_XOR:          c.aluop = ALU_XOR;
                    FN_NOR:          c.aluop = ALU_NOR;
                    FN_SLT:          c.aluop = ALU_SLT;
                    FN_SLTU:         c.aluop = ALU_SLTU;
                    FN_JR:           begin c = '0; c.jump = 2'b01; end
                    default:         begin c = '0; c.illegal = 1'b1; end
                endcase
            end
            OP_J:     c.jump = 2'b10;
            OP_JAL:   begin c.jump = 2'b11; c.regwrite = 1'b1; end
            OP_BEQ:   begin c.aluop = ALU_SUB; c.branch = 2'b01; end
            OP_BNE:   begin c.aluop = ALU_SUB; c.branch = 2'b10; end
            OP_ADDI, OP_ADDIU: begin c.alusrc = 1'b1; c.extop = 1'b1; c.regwrite = 1'b1; end
            OP_SLTI:  begin c.aluop = ALU_SLT; c.alusrc = 1'b1; c.extop = 1'b1; c.regwrite = 1'b1; end
            OP_SLTIU: begin c.aluop = ALU_SLTU; c.alusrc = 1'b1; c.extop = 1'b1; c.regwrite = 1'b1; end
            OP_ANDI:  begin c.aluop = ALU_AND; c.alusrc = 1'b1; c.regwrite = 1'b1; end
            OP_ORI:   begin c.aluop = ALU_OR; c.alusrc = 1'b1; c.regwrite = 1'b1; end
            OP_XORI:  begin c.aluop = ALU_XOR; c.alusrc = 1'b1; c.regwrite = 1'b1; end
            OP_LUI:   begin c.aluop = ALU_OR; c.back_pad = 1'b1; end
            OP_LW:    begin c.dren = 1'b1; c.memtoreg = 1'b1; end
            OP_SW:    c.dwen = 1'b1;
            OP_LL:    begin c.dren = 1'b1; c.memtoreg = 1'b1; c.datomic = 1'b1; end
            OP_SC:    begin c.dwen = 1'b1; c.memtoreg = 1'b1; c.regwrite = 1'b1; c.datomic = 1'b1; end
            OP_HALT:  c.halt = 1'b1;
            default:  c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    // A word that ends the instruction stream: HALT, or an unknown word when trapping.
    function automatic logic stops(input ctrl_t c);
        return c.halt || (TRAP_EN && c.illegal);
    endfunction

    assign in_ctrl     = decode(q.instr_in);
    assign q.in_ready  = (count_q != CNT_W'(DEPTH)) && !halt_seen_q && !halted_q;
    assign q.out_valid = (count_q != '0);
    assign enq         = q.in_valid && q.in_ready;
    assign deq         = q.out_valid && q.out_ready;
    assign wr_en       = enq && !q.flush;
    assign head_raw    = ctrl_mem_q[head_q];
    assign head_ctrl   = q.out_valid ? head_raw : '0;

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        halt_seen_d = halt_seen_q;
        halted_d    = halted_q;
        if (q.flush) begin
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            halt_seen_d = 1'b0;
        end else begin
            if (enq) begin
                tail_d = tail_q + 1'b1;
                if (stops(in_ctrl)) halt_seen_d = 1'b1;
            end
            if (deq) begin
                head_d = head_q + 1'b1;
                if (stops(head_raw)) halted_d = 1'b1;
            end
            count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            halt_seen_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            halt_seen_q <= halt_seen_d;
            halted_q    <= halted_d;
        end
    end

    // Storage needs no reset: every read is masked by out_valid.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            instr_mem_q[tail_q] <= q.instr_in;
            ctrl_mem_q[tail_q]  <= in_ctrl;
        end
    end

    assign q.out_instr = q.out_valid ? instr_mem_q[head_q] : '0;
    assign q.aluop     = head_ctrl.aluop;
    assign q.shamt     = head_ctrl.shamt;
    assign q.regdst    = head_ctrl.regdst;
    assign q.alusrc    = head_ctrl.alusrc;
    assign q.extop     = head_ctrl.extop;
    assign q.memtoreg  = head_ctrl.memtoreg;
    assign q.regwrite  = head_ctrl.regwrite;
    assign q.dren      = head_ctrl.dren;
    assign q.dwen      = head_ctrl.dwen;
    assign q.back_pad  = head_ctrl.back_pad;
    assign q.datomic   = head_ctrl.datomic;
    assign q.branch    = head_ctrl.branch;
    assign q.jump      = head_ctrl.jump;
    assign q.count     = count_q;
    assign q.halted    = halted_q;
    assign q.illegal   = TRAP_EN && head_ctrl.illegal;
endmodule
